// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: buffers packed operand words in a FIFO, issues them one
// at a time to booth_fsm over load/m/r/done, and holds each product on a
// valid/ready result port.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data    operand stream, in_data = {m, r}
//   load/m/r, product/done       booth_fsm handshake
//   out_valid/out_ready/out_data result stream
//   busy                         sequencer not idle
//   err/err_clr                  sticky timeout flag and its synchronous clear
//   op_count                     completed operations, wraps at 16 bits
module booth_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   in_data,
    output logic                      load,
    output logic [DATA_WIDTH-1:0]     m,
    output logic [DATA_WIDTH-1:0]     r,
    input  logic [2*DATA_WIDTH-1:0]   product,
    input  logic                      done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic                      busy,
    output logic                      err,
    input  logic                      err_clr,
    output logic [15:0]               op_count
);
    localparam int WW = 2 * DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     mem_q [DEPTH];
    logic [WW-1:0]     mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              out_valid_q, out_valid_d;
    logic [WW-1:0]     out_data_q, out_data_d;
    logic              err_q, err_d;
    logic [15:0]       op_count_q, op_count_d;

    logic              push;
    logic              pop;
    logic              timeout;
    logic              tmo_hit;
    logic [WW-1:0]     head;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT));

    assign load      = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign m         = m_q;
    assign r         = r_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign op_count  = op_count_q;

    // Sequencer FSM, result register, error flag and completion counter.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        r_d         = r_q;
        tmo_d       = tmo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;
        timeout     = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // A result still waiting for its consumer blocks issue.
                if (count_q != '0 && !out_valid_q) begin
                    pop     = 1'b1;
                    m_d     = head[WW-1:DATA_WIDTH];
                    r_d     = head[DATA_WIDTH-1:0];
                    tmo_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tmo_d = tmo_q + 1'b1;
                if (!done) begin
                    state_d = WAIT_DONE;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + 1'b1;
                if (done) begin
                    out_data_d  = product;
                    out_valid_d = 1'b1;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as a clear still leaves err set.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    // Operand FIFO; only the sequencer pops.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_q         <= '0;
            r_q         <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            m_q         <= m_d;
            r_q         <= r_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            op_count_q  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Bench for booth_op_sequencer: a behavioural booth_fsm stand-in plus a queue
// of accepted operand words from which every expected product is derived.
module tb_booth_op_sequencer;
    localparam int DW    = 32;
    localparam int WW    = 2 * DW;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          load;
    logic [DW-1:0] m;
    logic [DW-1:0] r;
    logic [WW-1:0] product = '0;
    logic          done = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic          busy;
    logic          err;
    logic          err_clr = 1'b0;
    logic [15:0]   op_count;

    int            n_pass = 0;
    int            n_total = 0;
    logic [15:0]   exp_cnt = '0;
    logic [WW-1:0] exp_q[$];

    int            booth_hang = 0;
    int            booth_lat = 0;
    int            b_cnt = 0;
    logic signed [WW-1:0] bm, br;

    booth_op_sequencer #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .load(load),
        .m(m),
        .r(r),
        .product(product),
        .done(done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .err(err),
        .err_clr(err_clr),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // booth_fsm stand-in: done falls after a load, rises with the signed
    // product a few cycles later. booth_hang makes it ignore load.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                b_cnt = 0;
                done  = 1'b1;
            end else if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    product = bm * br;
                    done    = 1'b1;
                end
            end else if (load && booth_hang == 0) begin
                bm      = $signed(m);
                br      = $signed(r);
                done    = 1'b0;
                product = {$urandom, $urandom};
                b_cnt   = (booth_lat > 0) ? booth_lat : $urandom_range(1, 4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [WW-1:0] ref_prod(input logic [WW-1:0] w);
        logic signed [WW-1:0] a, b;
        a = $signed(w[WW-1:DW]);
        b = $signed(w[DW-1:0]);
        return a * b;
    endfunction

    // Called at a negedge; returns at a negedge after the word is taken.
    task automatic push_word(input logic [WW-1:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!in_ready) begin
            $display("FAIL push_accept: in_ready=%0b required 1", in_ready);
        end else begin
            n_pass++;
            exp_q.push_back(w);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        logic [WW-1:0] w, e;
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!out_valid || exp_q.size() == 0) begin
            $display("FAIL %s_valid: out_valid=%0b queued=%0d required 1",
                     tag, out_valid, exp_q.size());
            out_ready = 1'b0;
            return;
        end
        n_pass++;
        w = exp_q.pop_front();
        e = ref_prod(w);
        exp_cnt++;
        n_total++;
        if (out_data !== e)
            $display("FAIL %s_data: got %h required %h", tag, out_data, e);
        else
            n_pass++;
        n_total++;
        if (op_count !== exp_cnt)
            $display("FAIL %s_count: got %0d required %0d", tag, op_count, exp_cnt);
        else
            n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL %s_accept: out_valid=%0b required 0", tag, out_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({in_ready, load, busy, out_valid, err} !== 5'b10000)
            $display("FAIL reset_flags: got %b required 10000",
                     {in_ready, load, busy, out_valid, err});
        else
            n_pass++;
        n_total++;
        if ({m, r, out_data, op_count} !== '0)
            $display("FAIL reset_data: m=%h r=%h out=%h cnt=%h required 0",
                     m, r, out_data, op_count);
        else
            n_pass++;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if ({busy, load, out_valid} !== 3'b000)
            $display("FAIL powerup_done: busy/load/out_valid=%b required 000",
                     {busy, load, out_valid});
        else
            n_pass++;
    endtask

    task automatic test_single();
        int n = 0;
        push_word({32'd7, 32'd6});
        while (!load && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (load !== 1'b1 || m !== 32'd7 || r !== 32'd6)
            $display("FAIL single_load: load=%0b m=%0d r=%0d required 1 7 6", load, m, r);
        else
            n_pass++;
        @(negedge clk);
        n_total++;
        if (load !== 1'b0 || busy !== 1'b1 || m !== 32'd7 || r !== 32'd6)
            $display("FAIL single_hold: load=%0b busy=%0b m=%0d r=%0d required 0 1 7 6",
                     load, busy, m, r);
        else
            n_pass++;
        collect("single");
    endtask

    task automatic test_signed();
        push_word({32'hFFFF_FFFD, 32'd5});
        collect("signed");
    endtask

    task automatic test_random();
        int k;
        for (int round = 0; round < 10; round++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                push_word({$urandom, $urandom});
            end
            for (int i = 0; i < k; i++) begin
                collect("random");
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic bad = 1'b0;
        out_ready = 1'b0;
        push_word({$urandom, $urandom});
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL bp_first: out_valid=%0b required 1", out_valid);
        else
            n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            push_word({$urandom, $urandom});
        end
        n_total++;
        if (in_ready !== 1'b0)
            $display("FAIL bp_full: in_ready=%0b required 0", in_ready);
        else
            n_pass++;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready || load || busy || !out_valid) bad = 1'b1;
        end
        in_valid = 1'b0;
        n_total++;
        if (bad !== 1'b0)
            $display("FAIL bp_block: stall violated=%0b required 0", bad);
        else
            n_pass++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            collect("bp");
        end
    endtask

    task automatic wait_err(output int cycles, output logic saw_ov);
        int n = 0;
        saw_ov = 1'b0;
        while (!load && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < TMO + 10) begin
            @(negedge clk);
            n++;
            if (out_valid) saw_ov = 1'b1;
        end
        cycles = n;
    endtask

    task automatic test_timeout();
        int cyc;
        logic ov;
        booth_hang = 1;
        push_word({32'd3, 32'd4});
        wait_err(cyc, ov);
        n_total++;
        if (err !== 1'b1 || cyc < TMO || cyc > TMO + 2)
            $display("FAIL timeout_err: err=%0b after %0d cycles required 1 in %0d..%0d",
                     err, cyc, TMO, TMO + 2);
        else
            n_pass++;
        n_total++;
        if (ov !== 1'b0 || op_count !== exp_cnt || busy !== 1'b0)
            $display("FAIL timeout_drop: ov=%0b cnt=%0d busy=%0b required 0 %0d 0",
                     ov, op_count, busy, exp_cnt);
        else
            n_pass++;
        void'(exp_q.pop_front());
        booth_hang = 0;
        push_word({32'd9, 32'd11});
        collect("after_timeout");
        n_total++;
        if (err !== 1'b1)
            $display("FAIL err_sticky: err=%0b required 1", err);
        else
            n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_total++;
        if (err !== 1'b0)
            $display("FAIL err_clr: err=%0b required 0", err);
        else
            n_pass++;
        err_clr    = 1'b1;
        booth_hang = 1;
        push_word({32'd1, 32'd2});
        wait_err(cyc, ov);
        n_total++;
        if (err !== 1'b1)
            $display("FAIL err_set_wins: err=%0b required 1", err);
        else
            n_pass++;
        void'(exp_q.pop_front());
        @(negedge clk);
        n_total++;
        if (err !== 1'b0)
            $display("FAIL err_clr_held: err=%0b required 0", err);
        else
            n_pass++;
        err_clr    = 1'b0;
        booth_hang = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic bad = 1'b0;
        booth_lat = 10;
        push_word({32'd100, 32'd200});
        while (!(busy && !load) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_total++;
        if ({in_ready, load, busy, out_valid, err} !== 5'b10000 ||
            {m, r, out_data, op_count} !== '0)
            $display("FAIL reset_mid: flags=%b m=%h r=%h out=%h cnt=%0d required 10000 and 0",
                     {in_ready, load, busy, out_valid, err}, m, r, out_data, op_count);
        else
            n_pass++;
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        booth_lat = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad = 1'b1;
        end
        n_total++;
        if (bad !== 1'b0)
            $display("FAIL reset_mid_quiet: stray activity=%0b required 0", bad);
        else
            n_pass++;
        push_word({32'hFFFF_FFFF, 32'hFFFF_FFFF});
        collect("post_reset");
    endtask

    task automatic test_wrap();
        force dut.op_count_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.op_count_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        n_total++;
        if (op_count !== 16'hFFFF)
            $display("FAIL wrap_preload: got %h required ffff", op_count);
        else
            n_pass++;
        push_word({32'd12345, 32'h8000_0000});
        collect("wrap");
        n_total++;
        if (op_count !== 16'h0000)
            $display("FAIL wrap_zero: got %h required 0000", op_count);
        else
            n_pass++;
        push_word({$urandom, $urandom});
        collect("wrap_next");
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_random();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/booth_op_sequencer.md
Name: booth_op_sequencer

Overview:
- Synthesizable operand/result sequencer between the operand stream (input-pipe transactor side) and booth_fsm.
- Buffers packed operand words in a small FIFO and drives booth_fsm's load/m/r handshake one operation at a time.
- Captures each product when booth_fsm signals done and presents it on a valid/ready result port for the output-pipe side.
- Replaces the ad-hoc done/issued logic in the transactor with a clean, verifiable stage.

Parameters:
- DATA_WIDTH, 32, width of each operand; product is 2*DATA_WIDTH.
- DEPTH, 4, operand FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, maximum cycles from load assertion to done returning high before an error is flagged.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operand word valid.
- in_ready  out  1  FIFO can accept a word (not full).
- in_data  in  2*DATA_WIDTH  packed operands: m = [2W-1:W], r = [W-1:0].
- load  out  1  to booth_fsm load.
- m  out  DATA_WIDTH  to booth_fsm multiplicand.
- r  out  DATA_WIDTH  to booth_fsm multiplier.
- product  in  2*DATA_WIDTH  from booth_fsm.
- done  in  1  from booth_fsm; low while computing, high when idle or finished.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_data  out  2*DATA_WIDTH  captured product.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err (synchronous).
- op_count  out  16  completed operations; wraps 0xFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; FIFO empty.
  - in_ready=1, load=0, m=0, r=0, out_valid=0, out_data=0, busy=0, err=0, op_count=0.
  - Assertion mid-operation aborts immediately; no result is produced for the in-flight operation.
- FIFO:
  - Push when in_valid & in_ready; in_ready = (count != DEPTH).
  - No bypass: a word pushed into an empty FIFO is visible to the FSM the next cycle.
  - Only the FSM pops. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- IDLE:
  - When FIFO non-empty and out_valid=0: pop head, register m/r from it, go to LOAD.
  - Otherwise stay. A pending result blocks issue.
  - done is ignored in IDLE; booth_fsm's done=1 at power-up never produces a result.
- LOAD:
  - load=1; m/r held stable. Timeout counter starts at 0 on entry and increments each cycle.
  - done==0 sampled -> WAIT_DONE, load=0 next cycle.
  - Counter reaching TIMEOUT -> err=1, load=0, go IDLE, no result, op_count unchanged; the operation is dropped.
- WAIT_DONE:
  - load=0; m/r still held; counter keeps running.
  - done==1 sampled -> out_data<=product, out_valid<=1, op_count+1, go IDLE.
  - Timeout -> same handling as in LOAD.
- Result port:
  - out_valid stays high and out_data stable until out_valid & out_ready, then out_valid<=0.
  - The next issue can occur the cycle after acceptance.
  - Minimum spacing between issues is therefore one cycle after result acceptance.
- err:
  - Set by timeout; cleared by err_clr.
  - If timeout and err_clr occur in the same cycle, set wins.
- Arithmetic: none performed; product is passed through unmodified and captured exactly once per operation.
- Latency: operand accepted -> load asserted at minimum 2 cycles (push, pop/register). Result latency is booth_fsm latency + 1 capture cycle.

Test Plan:
- Single op: push {32'd7,32'd6} -> load rises with m=7, r=6 held until done falls; out_valid with out_data=64'd42; op_count=1.
- Signed op: push {32'hFFFFFFFD,32'd5} -> out_data=64'hFFFFFFFFFFFFFFF1.
- Backpressure and full FIFO:
  - Hold out_ready=0 and push 6 words with DEPTH=4.
  - Required: the first op completes; in_ready drops after the FIFO holds 4 words, with one op in flight or held; no load while out_valid=1.
  - Release out_ready: all 5 accepted results emerge in order.
- Timeout: bench model never drops done after load -> err=1 after TIMEOUT cycles; no out_valid; next word still issues; err_clr clears err.
- Reset mid-op: deassert-then-assert reset during WAIT_DONE -> all outputs return to reset values immediately; FIFO empty; a subsequent op completes normally.
- Counter wrap: preload via 65536 ops (or force op_count=16'hFFFF) -> next completion gives op_count=0.
